// File: rtl/dist_accumulator.sv
// Squared-difference accumulator: captures one beat of LANES operand pairs and
// folds (a-b)^2 of each lane into a saturating running sum, one lane per cycle.
module dist_accumulator #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int SUM_W  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    acc_en_i,
  input  logic                    acc_rst_i,
  input  logic                    acc_pre_i,
  input  logic                    data_valid_i,
  input  logic [LANES*DATA_W-1:0] a_data_i,
  input  logic [LANES*DATA_W-1:0] b_data_i,
  output logic                    data_ready_o,
  output logic                    acc_rdy_o,
  output logic [SUM_W-1:0]        acc_sum_o,
  output logic                    overflow_o
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

  state_t                  state_q;
  logic [LANE_W-1:0]       lane_q;
  logic [LANES*DATA_W-1:0] a_q, b_q;
  logic [SUM_W-1:0]        sum_q;
  logic                    ovf_q;
  logic                    rdy_q;

  logic [DATA_W-1:0]       a_lane, b_lane, abs_diff;
  logic [2*DATA_W-1:0]     abs_ext, sq;
  logic [SUM_W:0]          sum_ext;
  logic [SUM_W-1:0]        sum_d;
  logic                    carry_d;

  // |a-b|^2 equals (a-b)^2 and keeps the multiply unsigned and exact.
  assign a_lane   = a_q[lane_q*DATA_W +: DATA_W];
  assign b_lane   = b_q[lane_q*DATA_W +: DATA_W];
  assign abs_diff = (a_lane >= b_lane) ? (a_lane - b_lane) : (b_lane - a_lane);
  assign abs_ext  = {{DATA_W{1'b0}}, abs_diff};
  assign sq       = abs_ext * abs_ext;

  always_comb begin
    sum_ext = {1'b0, sum_q} + {{(SUM_W + 1 - 2*DATA_W){1'b0}}, sq};
    carry_d = sum_ext[SUM_W];
    sum_d   = carry_d ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lane_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else if (acc_en_i) begin
      if (acc_rst_i) begin
        state_q <= LOAD;
        lane_q  <= '0;
        rdy_q   <= 1'b0;
        if (!acc_pre_i) begin
          sum_q <= '0;
          ovf_q <= 1'b0;
        end
      end else begin
        case (state_q)
          IDLE: ;
          LOAD: begin
            if (data_valid_i) begin
              a_q     <= a_data_i;
              b_q     <= b_data_i;
              state_q <= MAC;
            end
          end
          MAC: begin
            sum_q <= sum_d;
            if (carry_d) ovf_q <= 1'b1;
            if (lane_q == LANE_W'(LANES - 1)) begin
              lane_q  <= '0;
              state_q <= DONE;
              rdy_q   <= 1'b1;
            end else begin
              lane_q <= lane_q + LANE_W'(1);
            end
          end
          DONE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // A restart in LOAD wins over the beat, so ready drops to avoid a lost beat.
  assign data_ready_o = acc_en_i && !acc_rst_i && (state_q == LOAD);
  assign acc_rdy_o    = rdy_q;
  assign acc_sum_o    = sum_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_dist_accumulator.sv
// Directed bench for dist_accumulator: table of full passes plus hand-written
// freeze, abort, saturation and async-reset sequences.
module tb_dist_accumulator;

  logic        clk;
  logic        rst;
  logic        acc_en, acc_rst, acc_pre, data_valid;
  logic [31:0] a_data, b_data;
  logic        data_ready, acc_rdy, overflow;
  logic [31:0] acc_sum;
  logic        data_ready_s, acc_rdy_s, overflow_s;
  logic [15:0] acc_sum_s;

  int n_tests = 0;
  int n_fail  = 0;

  dist_accumulator #(.DATA_W(8), .LANES(4), .SUM_W(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .acc_en_i(acc_en), .acc_rst_i(acc_rst),
    .acc_pre_i(acc_pre), .data_valid_i(data_valid), .a_data_i(a_data),
    .b_data_i(b_data), .data_ready_o(data_ready), .acc_rdy_o(acc_rdy),
    .acc_sum_o(acc_sum), .overflow_o(overflow)
  );

  dist_accumulator #(.DATA_W(8), .LANES(4), .SUM_W(16)) u_sat (
    .clk_i(clk), .rst_i(rst), .acc_en_i(acc_en), .acc_rst_i(acc_rst),
    .acc_pre_i(acc_pre), .data_valid_i(data_valid), .a_data_i(a_data),
    .b_data_i(b_data), .data_ready_o(data_ready_s), .acc_rdy_o(acc_rdy_s),
    .acc_sum_o(acc_sum_s), .overflow_o(overflow_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pre;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_sum;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_pass(input logic pre);
    acc_en  = 1'b1;
    acc_rst = 1'b1;
    acc_pre = pre;
    @(posedge clk); #1;
    acc_rst = 1'b0;
    #1;
    check("t0_acc_rdy", acc_rdy, 0);
    check("t0_data_ready", data_ready, 1);
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b);
    data_valid = 1'b1;
    a_data     = a;
    b_data     = b;
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic wait_rdy(output int cyc);
    cyc = 0;
    while (!acc_rdy && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] prev;

    // Lane 0 is the low byte: a={10,20,30,40} -> 32'h281E140A.
    vecs[0] = '{1'b0, 32'h281E140A, 32'h241E1907, 32'd50};
    vecs[1] = '{1'b1, 32'h00000000, 32'h01010101, 32'd54};
    vecs[2] = '{1'b0, 32'h00000000, 32'h00000000, 32'd0};
    vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'h00000000, 32'd260100};
    vecs[4] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 32'd520200};
    vecs[5] = '{1'b0, 32'h04030201, 32'h01020304, 32'd20};

    rst = 1'b1; acc_en = 1'b0; acc_rst = 1'b0; acc_pre = 1'b0;
    data_valid = 1'b0; a_data = '0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", acc_sum, 0);
    check("rst_rdy", acc_rdy, 0);
    check("rst_ready", data_ready, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;

    prev = 32'd0;
    for (int i = 0; i < 6; i++) begin
      start_pass(vecs[i].pre);
      check($sformatf("v%0d_t0_sum", i), acc_sum, vecs[i].pre ? prev : 32'd0);
      send_beat(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_ready_mac", i), data_ready, 0);
      wait_rdy(cyc);
      check($sformatf("v%0d_latency", i), cyc, 4);
      check($sformatf("v%0d_sum", i), acc_sum, vecs[i].exp_sum);
      check($sformatf("v%0d_ovf", i), overflow, 0);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_hold", i), acc_sum, vecs[i].exp_sum);
      prev = vecs[i].exp_sum;
    end

    // Saturation on the 16-bit instance.
    start_pass(1'b0);
    send_beat(32'hFFFFFFFF, 32'h00000000);
    wait_rdy(cyc);
    check("sat_sum", acc_sum_s, 16'hFFFF);
    check("sat_ovf", overflow_s, 1);
    check("sat_rdy", acc_rdy_s, 1);
    start_pass(1'b1);
    send_beat(32'h0, 32'h0);
    wait_rdy(cyc);
    check("sat_keep_ovf", overflow_s, 1);
    check("sat_keep_sum", acc_sum_s, 16'hFFFF);
    start_pass(1'b0);
    send_beat(32'h0, 32'h0);
    wait_rdy(cyc);
    check("sat_clr_ovf", overflow_s, 0);
    check("sat_clr_sum", acc_sum_s, 0);

    // Freeze after two lane edges.
    start_pass(1'b0);
    send_beat(vecs[0].a, vecs[0].b);
    repeat (2) begin @(posedge clk); #1; end
    check("frz_sum_pre", acc_sum, 34);
    acc_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("frz_sum_%0d", k), acc_sum, 34);
      check($sformatf("frz_ready_%0d", k), data_ready, 0);
      check($sformatf("frz_rdy_%0d", k), acc_rdy, 0);
    end
    acc_en = 1'b1;
    wait_rdy(cyc);
    check("frz_remaining", cyc, 2);
    check("frz_sum", acc_sum, 50);

    // Abort mid-MAC with a clearing restart.
    start_pass(1'b0);
    send_beat(vecs[0].a, vecs[0].b);
    repeat (2) begin @(posedge clk); #1; end
    acc_rst = 1'b1; acc_pre = 1'b0;
    @(posedge clk); #1;
    acc_rst = 1'b0;
    #1;
    check("abt_sum", acc_sum, 0);
    check("abt_ready", data_ready, 1);
    check("abt_rdy", acc_rdy, 0);
    send_beat(vecs[5].a, vecs[5].b);
    wait_rdy(cyc);
    check("abt_latency", cyc, 4);
    check("abt_sum_new", acc_sum, 20);

    // Async reset between edges mid-MAC.
    start_pass(1'b0);
    send_beat(vecs[0].a, vecs[0].b);
    @(posedge clk); #1;
    check("ar_sum_pre", acc_sum, 9);
    #3;
    rst = 1'b1;
    #1;
    check("ar_sum", acc_sum, 0);
    check("ar_rdy", acc_rdy, 0);
    check("ar_ready", data_ready, 0);
    check("ar_ovf", overflow, 0);
    rst = 1'b0;
    data_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("ar_idle_ready", data_ready, 0);
    check("ar_idle_sum", acc_sum, 0);
    check("ar_idle_rdy", acc_rdy, 0);
    data_valid = 1'b0;
    start_pass(1'b0);
    send_beat(vecs[5].a, vecs[5].b);
    wait_rdy(cyc);
    check("ar_after_sum", acc_sum, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
